alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Byte-serial front/back end for the 16-bit ALU, placed directly upstream and downstream of it.
- Accepts an opcode and four operand bytes from the 8-bit internal bus over a valid/ready handshake, then holds them in registers that drive the ALU operand ports.
- Captures the ALU's combinational 16-bit result and flags in one execute cycle, then returns the result to the bus as two bytes, low byte first.
- Gives the ALU stable registered inputs so its combinational path is one clock stage.

Parameters:
- BYTE_W, 8, bus and operand byte width; only 8 is supported.
- IDLE_OP, 8'h00, opcode driven on alu_op after reset and after flush.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns FSM to S_OP
- in_data  input  8  opcode/operand byte stream
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- out_data  output  8  result byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in every state except S_OP
- zero_flag  output  1  captured ALU zero flag
- over_flag  output  1  captured ALU overflow flag
- alu_op  output  8  opcode to ALU operation port
- alu_a_low, alu_a_high, alu_b_low, alu_b_high  output  8 each  registered operand bytes to ALU
- alu_res_low, alu_res_high  input  8 each  ALU result
- alu_zerof, alu_overf  input  1 each  ALU flags

Behaviour:
- Reset (rst_n low, async): state=S_OP; alu_op=IDLE_OP; all operand registers, result registers, out_data, zero_flag and over_flag = 0; in_ready=1; out_valid=0; busy=0.
- States advance S_OP -> S_AL -> S_AH -> S_BL -> S_BH -> S_EXEC -> S_OUTL -> S_OUTH -> S_OP.
- Load states (S_OP..S_BH):
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge, the byte is stored into op/a_low/a_high/b_low/b_high respectively and the FSM advances.
  - Without in_valid the FSM holds.
- Operand registers drive the ALU ports directly and continuously. Each operand register changes only when its own byte is accepted.
- S_EXEC:
  - Lasts exactly one cycle; in_ready=0.
  - At its closing edge: res_low/res_high <= alu_res_low/high, zero_flag <= alu_zerof, over_flag <= alu_overf. Then go to S_OUTL.
- S_OUTL: out_valid=1, out_data=res_low. On out_ready, advance to S_OUTH.
- S_OUTH: out_valid=1, out_data=res_high. On out_ready, advance to S_OP.
- While out_valid=1, out_data is stable until accepted.
- In S_OP..S_BH, out_valid=0 and out_data=0.
- Latency: the edge accepting the b_high byte is E. S_EXEC is the cycle after E, and out_valid rises one cycle after that (E+2). Minimum 8 cycles per operation.
- zero_flag/over_flag hold their values until the next S_EXEC capture. flush does not clear them.
- flush:
  - Sampled at the clock edge and takes priority over the handshakes.
  - Effect: state=S_OP, alu_op=IDLE_OP, no byte accepted or emitted that cycle, result output withdrawn.
  - Operand, result and flag registers keep their values.
- Reset mid-operation: all state is lost immediately, asynchronously.
- The block passes opcodes through unchecked; unknown opcodes yield whatever the ALU produces.

Test Plan:
- Reset: assert rst_n=0 mid-load -> in_ready=1, out_valid=0, busy=0, zero_flag=0, over_flag=0, alu_op=8'h00 immediately, without waiting for a clock edge.
- Add: stream ALU_ADD,34,12,FF,0F with in_valid held -> after E, one S_EXEC cycle; out_valid rises at E+2; bytes 33 then 22 with out_ready=1; over_flag=0; busy falls after the second byte.
- Overflow: ALU_ADD, FF,FF,01,00 -> bytes 00,00; over_flag=1. A following ALU_ADD 01,00,01,00 -> bytes 02,00; over_flag returns to 0.
- Backpressure: gaps in in_valid (2 idle cycles between each byte) and out_ready low for 5 cycles in S_OUTL -> no lost or duplicated bytes; out_data stays at 33 throughout the stall.
- Flush: pulse flush after a_high is accepted -> S_OP, alu_op=00, in_ready=1. A full new ALU_ADD transaction then produces the correct sum.
- Flush during S_OUTH -> out_valid drops the next cycle; the high byte is never emitted; flags keep their captured values.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: byte-serial operand loader and result unloader around a combinational 16-bit ALU
module alu_seq #(
    parameter int                BYTE_W  = 8,
    parameter logic [BYTE_W-1:0] IDLE_OP = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              zero_flag,
    output logic              over_flag,
    output logic [BYTE_W-1:0] alu_op,
    output logic [BYTE_W-1:0] alu_a_low,
    output logic [BYTE_W-1:0] alu_a_high,
    output logic [BYTE_W-1:0] alu_b_low,
    output logic [BYTE_W-1:0] alu_b_high,
    input  logic [BYTE_W-1:0] alu_res_low,
    input  logic [BYTE_W-1:0] alu_res_high,
    input  logic              alu_zerof,
    input  logic              alu_overf
);
    localparam logic [2:0] S_OP   = 3'd0;
    localparam logic [2:0] S_AL   = 3'd1;
    localparam logic [2:0] S_AH   = 3'd2;
    localparam logic [2:0] S_BL   = 3'd3;
    localparam logic [2:0] S_BH   = 3'd4;
    localparam logic [2:0] S_EXEC = 3'd5;
    localparam logic [2:0] S_OUTL = 3'd6;
    localparam logic [2:0] S_OUTH = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [BYTE_W-1:0] op_q, op_d, a_low_q, a_low_d, a_high_q, a_high_d;
    logic [BYTE_W-1:0] b_low_q, b_low_d, b_high_q, b_high_d;
    logic [BYTE_W-1:0] res_low_q, res_low_d, res_high_q, res_high_d;
    logic              zero_q, zero_d, over_q, over_d;
    logic              load, exec, emit;

    assign in_ready   = state_q <= S_BH;
    assign out_valid  = state_q == S_OUTL || state_q == S_OUTH;
    assign out_data   = state_q == S_OUTL ? res_low_q : state_q == S_OUTH ? res_high_q : '0;
    assign busy       = state_q != S_OP;
    assign zero_flag  = zero_q;
    assign over_flag  = over_q;
    assign alu_op     = op_q;
    assign alu_a_low  = a_low_q;
    assign alu_a_high = a_high_q;
    assign alu_b_low  = b_low_q;
    assign alu_b_high = b_high_q;

    // States are numbered in sequence so every advance is +1, S_OUTH wrapping to S_OP.
    always_comb begin
        load       = in_valid && in_ready && !flush;
        exec       = state_q == S_EXEC && !flush;
        emit       = out_valid && out_ready && !flush;
        state_d    = flush ? S_OP : (load || exec || emit) ? state_q + 3'd1 : state_q;
        op_d       = flush ? IDLE_OP : (load && state_q == S_OP) ? in_data : op_q;
        a_low_d    = (load && state_q == S_AL) ? in_data : a_low_q;
        a_high_d   = (load && state_q == S_AH) ? in_data : a_high_q;
        b_low_d    = (load && state_q == S_BL) ? in_data : b_low_q;
        b_high_d   = (load && state_q == S_BH) ? in_data : b_high_q;
        res_low_d  = exec ? alu_res_low : res_low_q;
        res_high_d = exec ? alu_res_high : res_high_q;
        zero_d     = exec ? alu_zerof : zero_q;
        over_d     = exec ? alu_overf : over_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OP;
            op_q       <= IDLE_OP;
            a_low_q    <= '0;
            a_high_q   <= '0;
            b_low_q    <= '0;
            b_high_q   <= '0;
            res_low_q  <= '0;
            res_high_q <= '0;
            zero_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_low_q    <= a_low_d;
            a_high_q   <= a_high_d;
            b_low_q    <= b_low_d;
            b_high_q   <= b_high_d;
            res_low_q  <= res_low_d;
            res_high_q <= res_high_d;
            zero_q     <= zero_d;
            over_q     <= over_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors against alu_seq with a 16-bit add ALU model and an output scoreboard
module tb_alu_seq;
    localparam logic [7:0] ALU_ADD = 8'h01;

    logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, busy, zero_flag, over_flag;
    logic [7:0] out_data, alu_op, alu_a_low, alu_a_high, alu_b_low, alu_b_high;
    logic [7:0] alu_res_low, alu_res_high;
    logic       alu_zerof, alu_overf;
    logic [16:0] sum;
    logic [7:0] exp_q[$];
    int checks = 0, fails = 0;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .zero_flag(zero_flag), .over_flag(over_flag),
        .alu_op(alu_op), .alu_a_low(alu_a_low), .alu_a_high(alu_a_high),
        .alu_b_low(alu_b_low), .alu_b_high(alu_b_high),
        .alu_res_low(alu_res_low), .alu_res_high(alu_res_high),
        .alu_zerof(alu_zerof), .alu_overf(alu_overf)
    );

    always #5 clk = ~clk;

    assign sum = {1'b0, alu_a_high, alu_a_low} + {1'b0, alu_b_high, alu_b_low};
    assign {alu_res_high, alu_res_low} = (alu_op == ALU_ADD) ? sum[15:0] : 16'h0;
    assign alu_overf = (alu_op == ALU_ADD) && sum[16];
    assign alu_zerof = {alu_res_high, alu_res_low} == 16'h0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A byte is emitted at the next edge when valid and ready are seen here and no flush overrides it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out_byte: got %h expected no byte", out_data);
            end else check("out_byte", {8'h00, out_data}, {8'h00, exp_q.pop_front()});
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 50) begin
                checks++;
                fails++;
                $display("FAIL send_timeout: got in_ready=0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic txn(input logic [7:0] al, ah, bl, bh, input int gap,
                       input logic [7:0] lo, hi, input bit push_hi);
        exp_q.push_back(lo);
        if (push_hi) exp_q.push_back(hi);
        send(ALU_ADD, gap);
        send(al, gap);
        send(ah, gap);
        send(bl, gap);
        send(bh, gap);
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        checks++;
        fails++;
        $display("FAIL %s_timeout: got busy=%b pending=%0d expected idle", name, busy, exp_q.size());
    endtask

    task automatic wait_out_valid();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        checks++;
        fails++;
        $display("FAIL out_valid_timeout: got 0 expected 1");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", {15'h0, in_ready}, 16'h1);
        check("rst_out_valid", {15'h0, out_valid}, 16'h0);
        check("rst_busy", {15'h0, busy}, 16'h0);
        check("rst_alu_op", {8'h0, alu_op}, 16'h0);
        check("rst_flags", {14'h0, zero_flag, over_flag}, 16'h0);
        @(posedge clk);
        #1;

        // Add with in_valid held; S_EXEC after E, out_valid at E+2
        txn(8'h34, 8'h12, 8'hFF, 8'h0F, 0, 8'h33, 8'h22, 1'b1);
        @(negedge clk);
        check("exec_state", {13'h0, out_valid, in_ready, busy}, 16'h1);
        @(negedge clk);
        check("e2_out_valid", {15'h0, out_valid}, 16'h1);
        wait_idle("add");
        check("add_flags", {14'h0, zero_flag, over_flag}, 16'h0);

        // Overflow then a clean add clears the flag
        @(posedge clk);
        #1;
        txn(8'hFF, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'h00, 1'b1);
        wait_idle("ovf");
        check("ovf_flags", {14'h0, zero_flag, over_flag}, 16'h3);
        @(posedge clk);
        #1;
        txn(8'h01, 8'h00, 8'h01, 8'h00, 0, 8'h02, 8'h00, 1'b1);
        wait_idle("ovf_clear");
        check("ovf_clear_flags", {14'h0, zero_flag, over_flag}, 16'h0);

        // Input gaps and a stalled consumer
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        txn(8'h34, 8'h12, 8'hFF, 8'h0F, 2, 8'h33, 8'h22, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {7'h0, out_valid, out_data}, 16'h0133);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("stall");

        // Flush after a_high is accepted
        @(posedge clk);
        #1;
        send(ALU_ADD, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_state", {13'h0, busy, in_ready, out_valid}, 16'h2);
        check("flush_alu_op", {8'h0, alu_op}, 16'h0);
        check("flush_keep_a", {alu_a_high, alu_a_low}, 16'h6655);
        @(posedge clk);
        #1;
        txn(8'h01, 8'h02, 8'h03, 8'h04, 0, 8'h04, 8'h06, 1'b1);
        wait_idle("after_flush");

        // Flush in S_OUTH overrides out_ready; high byte never emitted
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        txn(8'hFF, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 8'h00, 1'b0);
        wait_out_valid();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("outh_before_flush", {7'h0, out_valid, busy, 7'h0}, 16'h0180);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("outh_flushed", {7'h0, out_valid, out_data}, 16'h0000);
        check("outh_flags_kept", {14'h0, zero_flag, over_flag}, 16'h3);
        check("outh_no_pending", exp_q.size(), 16'h0);

        // Asynchronous reset mid-load clears flags and operands without a clock edge
        @(posedge clk);
        #1;
        send(ALU_ADD, 0);
        send(8'h77, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_hs", {13'h0, in_ready, out_valid, busy}, 16'h4);
        check("arst_flags", {14'h0, zero_flag, over_flag}, 16'h0);
        check("arst_regs", {alu_op, alu_a_low}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(8'h34, 8'h12, 8'hFF, 8'h0F, 0, 8'h33, 8'h22, 1'b1);
        wait_idle("post_reset");
        check("final_pending", exp_q.size(), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
